// File: rtl/icap_cfg_pkg.sv
// Shared reader-state type, ICAPE2 constants and the per-byte bit-reversal helper.
package icap_cfg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  localparam logic        CSIB_OFF       = 1'b1;
  localparam logic        RDWRB_WR       = 1'b0;
  localparam logic [31:0] ICAP_SYNC_WORD = 32'hAA995566;

  // ICAP expects each byte MSB/LSB-mirrored while byte positions stay put.
  function automatic logic [31:0] bitswap_bytes(input logic [31:0] i_word);
    logic [31:0] r_out;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        r_out[8*k+j] = i_word[8*k+7-j];
      end
    end
    return r_out;
  endfunction

endpackage

// File: rtl/icap_config_buffer_if.sv
// Bus bundle between the config controller (master) and icap_config_buffer (slave).
interface icap_config_buffer_if #(
  parameter int DEPTH = 512
);
  localparam int CW = $clog2(DEPTH) + 2;

  logic [63:0]   i_din;
  logic          i_wr_en;
  logic          o_full;
  logic          o_prog_full;
  logic          o_empty;
  logic          o_overflow;
  logic [CW-1:0] o_word_cnt;
  logic          o_icap_csib;
  logic          o_icap_rdwrb;
  logic [31:0]   o_icap_data;

  modport slave (
    input  i_din, i_wr_en,
    output o_full, o_prog_full, o_empty, o_overflow, o_word_cnt,
    output o_icap_csib, o_icap_rdwrb, o_icap_data
  );

  modport master (
    output i_din, i_wr_en,
    input  o_full, o_prog_full, o_empty, o_overflow, o_word_cnt,
    input  o_icap_csib, o_icap_rdwrb, o_icap_data
  );

endinterface

// File: rtl/icap_fifo_64to32.sv
// Single-clock 64-bit-in / 32-bit-out FIFO: upper word of each beat is read first.
module icap_fifo_64to32 #(
  parameter int DEPTH            = 512,
  parameter int PROG_FULL_THRESH = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [63:0]              i_din,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [31:0]              o_dout,
  output logic                     o_full,
  output logic                     o_prog_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH)+1:0] o_word_cnt
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] PF_LEVEL = PROG_FULL_THRESH[AW:0];

  logic [63:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW+1:0] r_rd_ptr;
  logic          r_full, r_prog_full, r_empty, r_overflow;
  logic [AW+1:0] r_word_cnt;

  logic          w_wr, w_rd;
  logic [AW:0]   w_wr_ptr_nxt, w_rd_ent_nxt, w_occ_nxt;
  logic [AW+1:0] w_rd_ptr_nxt, w_cnt_nxt;
  logic [63:0]   w_entry;

  assign w_wr = i_wr_en && !r_full;
  assign w_rd = i_rd_en && !r_empty;

  // Read pointer counts words; its upper bits are the entry pointer.
  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_wr};
  assign w_rd_ptr_nxt = r_rd_ptr + {{(AW+1){1'b0}}, w_rd};
  assign w_rd_ent_nxt = w_rd_ptr_nxt[AW+1:1];
  assign w_occ_nxt    = w_wr_ptr_nxt - w_rd_ent_nxt;
  assign w_cnt_nxt    = {w_wr_ptr_nxt, 1'b0} - w_rd_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_word_cnt  <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_prog_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_word_cnt  <= w_cnt_nxt;
      r_empty     <= (w_cnt_nxt == '0);
      // A half-read entry still counts as occupied.
      r_full      <= (w_wr_ptr_nxt[AW] != w_rd_ent_nxt[AW]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ent_nxt[AW-1:0]);
      r_prog_full <= (w_occ_nxt >= PF_LEVEL);
      if (i_wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  assign w_entry     = r_mem[r_rd_ptr[AW:1]];
  assign o_dout      = r_rd_ptr[0] ? w_entry[31:0] : w_entry[63:32];
  assign o_full      = r_full;
  assign o_prog_full = r_prog_full;
  assign o_empty     = r_empty;
  assign o_overflow  = r_overflow;
  assign o_word_cnt  = r_word_cnt;

endmodule

// File: rtl/icap_config_buffer.sv
// DMA-to-ICAPE2 config buffer: FIFO, reader FSM and registered ICAP output stage.
// Define ICAP_BITSWAP_EN to mirror bits within each byte; leave undefined for pre-swapped bitstreams.
module icap_config_buffer
  import icap_cfg_pkg::*;
#(
  parameter int DEPTH            = 512,
  parameter int PROG_FULL_THRESH = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  icap_config_buffer_if.slave   bus_if
);
  // state  | meaning
  // IDLE   | ICAP deselected, waiting for a pending word
  // STREAM | popping one word per cycle into ICAP

  rd_state_e   r_state, w_state_nxt;
  logic        w_pop_fsm, w_pop, w_empty;
  logic [31:0] w_fifo_dout, w_word_out;
  logic        r_csib, r_rdwrb;
  logic [31:0] r_data;

  icap_fifo_64to32 #(
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (PROG_FULL_THRESH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_din       (bus_if.i_din),
    .i_wr_en     (bus_if.i_wr_en),
    .i_rd_en     (w_pop),
    .o_dout      (w_fifo_dout),
    .o_full      (bus_if.o_full),
    .o_prog_full (bus_if.o_prog_full),
    .o_empty     (w_empty),
    .o_overflow  (bus_if.o_overflow),
    .o_word_cnt  (bus_if.o_word_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // IDLE pops on the way out so the first word lands two cycles after its write.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_fsm   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop_fsm   = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_empty) w_state_nxt = IDLE;
        else         w_pop_fsm   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop = w_pop_fsm;

`ifdef ICAP_BITSWAP_EN
  assign w_word_out = bitswap_bytes(w_fifo_dout);
`else
  assign w_word_out = w_fifo_dout;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csib  <= CSIB_OFF;
      r_rdwrb <= ~RDWRB_WR;
      r_data  <= '0;
    end else begin
      r_csib  <= w_pop ? ~CSIB_OFF : CSIB_OFF;
      r_rdwrb <= w_pop ? RDWRB_WR : ~RDWRB_WR;
      if (w_pop) r_data <= w_word_out;
    end
  end

  assign bus_if.o_empty      = w_empty;
  assign bus_if.o_icap_csib  = r_csib;
  assign bus_if.o_icap_rdwrb = r_rdwrb;
  assign bus_if.o_icap_data  = r_data;

endmodule

// File: tb/tb_icap_config_buffer.sv
// Bench for icap_config_buffer: latency vector table, scoreboard-checked ICAP word stream.
module tb_icap_config_buffer;
  import icap_cfg_pkg::*;

  localparam int DEPTH  = 512;
  localparam int THRESH = 480;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icap_config_buffer_if #(.DEPTH(DEPTH)) ifc ();

  icap_config_buffer #(
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (THRESH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_if  (ifc)
  );

  typedef struct {
    logic [63:0] din;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] sb_q [$];
  logic [31:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Whole-word mirror followed by byte-order reversal equals per-byte mirroring.
  function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [31:0] t;
    t = {<<{w}};
    return {<<8{t}};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of write-side stimulus; accepted beats go to the scoreboard.
  task automatic step(input logic en, input logic [63:0] d);
    ifc.i_wr_en = en;
    ifc.i_din   = d;
    if (en && !ifc.o_full) begin
      sb_q.push_back(ref_word(d[63:32]));
      sb_q.push_back(ref_word(d[31:0]));
    end
    @(posedge clk);
    #1;
    ifc.i_wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((sb_q.size() != 0 || !ifc.o_icap_csib) && c < budget) begin
      step(1'b0, '0);
      c++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.o_icap_csib == 1'b0) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word", ifc.o_icap_data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("icap_word", 64'(ifc.o_icap_data), 64'(mon_exp));
        check("rdwrb_active", 64'(ifc.o_icap_rdwrb), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, last, cnt0, run, sent, cyc;
    logic broken;

`ifdef ICAP_BITSWAP_EN
    vecs[0] = '{64'h5599_66AA_0000_0001, 32'hAA99_6655, 32'h0000_0080};
    vecs[1] = '{64'hFFFF_0000_8001_0F0F, 32'hFFFF_0000, 32'h0180_F0F0};
    vecs[2] = '{{ICAP_SYNC_WORD, 32'h1234_5678}, 32'h5599_66AA, 32'h482C_6A1E};
`else
    vecs[0] = '{64'h5599_66AA_0000_0001, 32'h5599_66AA, 32'h0000_0001};
    vecs[1] = '{64'hFFFF_0000_8001_0F0F, 32'hFFFF_0000, 32'h8001_0F0F};
    vecs[2] = '{{ICAP_SYNC_WORD, 32'h1234_5678}, 32'hAA99_5566, 32'h1234_5678};
`endif
    vecs[3] = '{64'h0000_0000_FFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};

    ifc.i_wr_en = 1'b0;
    ifc.i_din   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csib",      64'(ifc.o_icap_csib),  64'd1);
    check("rst_rdwrb",     64'(ifc.o_icap_rdwrb), 64'd1);
    check("rst_data",      64'(ifc.o_icap_data),  64'd0);
    check("rst_empty",     64'(ifc.o_empty),      64'd1);
    check("rst_full",      64'(ifc.o_full),       64'd0);
    check("rst_prog_full", 64'(ifc.o_prog_full),  64'd0);
    check("rst_overflow",  64'(ifc.o_overflow),   64'd0);
    check("rst_word_cnt",  64'(ifc.o_word_cnt),   64'd0);
    rst_n = 1'b1;
    repeat (4) step(1'b0, '0);
    check("idle_csib",     64'(ifc.o_icap_csib),  64'd1);
    check("idle_empty",    64'(ifc.o_empty),      64'd1);
    check("idle_word_cnt", 64'(ifc.o_word_cnt),   64'd0);

    for (int v = 0; v < 4; v++) begin
      step(1'b1, vecs[v].din);
      check("lat_empty_n1", 64'(ifc.o_empty),      64'd0);
      step(1'b0, '0);
      check("lat_csib_n2",  64'(ifc.o_icap_csib),  64'd0);
      check("lat_data_n2",  64'(ifc.o_icap_data),  64'(vecs[v].exp0));
      step(1'b0, '0);
      check("lat_csib_n3",  64'(ifc.o_icap_csib),  64'd0);
      check("lat_data_n3",  64'(ifc.o_icap_data),  64'(vecs[v].exp1));
      step(1'b0, '0);
      check("lat_csib_n4",  64'(ifc.o_icap_csib),  64'd1);
      check("lat_rdwrb_n4", 64'(ifc.o_icap_rdwrb), 64'd1);
      check("lat_hold_n4",  64'(ifc.o_icap_data),  64'(vecs[v].exp1));
    end

    first = -1; last = -1; cnt0 = 0;
    for (int i = 0; i < 26; i++) begin
      step(i < 8, {32'hC000_0000 + 32'(2*i), 32'hC000_0000 + 32'(2*i+1)});
      if (ifc.o_icap_csib == 1'b0) begin
        if (first < 0) first = i;
        last = i;
        cnt0++;
      end
    end
    check("b2b_first", 64'(first),        64'd1);
    check("b2b_count", 64'(cnt0),         64'd16);
    check("b2b_span",  64'(last - first), 64'd15);

    force dut.w_pop = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, {32'hB000_0000 + 32'(2*i), 32'hB000_0000 + 32'(2*i+1)});
    check("burst_word_cnt", 64'(ifc.o_word_cnt), 64'd16);
    release dut.w_pop;
    run = 0; broken = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, '0);
      if (ifc.o_icap_csib == 1'b0 && !broken) run++;
      else broken = 1'b1;
    end
    check("burst_run", 64'(run), 64'd16);
    drain(64);

    force dut.w_pop = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, {32'hF000_0000 + 32'(2*k), 32'hF000_0000 + 32'(2*k+1)});
      if (k == THRESH - 1) check("pf_below", 64'(ifc.o_prog_full), 64'd0);
      if (k == THRESH)     check("pf_at",    64'(ifc.o_prog_full), 64'd1);
      if (k == DEPTH - 1)  check("full_below", 64'(ifc.o_full),  64'd0);
      if (k == DEPTH) begin
        check("full_at",       64'(ifc.o_full),     64'd1);
        check("full_word_cnt", 64'(ifc.o_word_cnt), 64'(2*DEPTH));
      end
    end
    check("ovf_before", 64'(ifc.o_overflow), 64'd0);
    step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    check("ovf_set",      64'(ifc.o_overflow), 64'd1);
    check("ovf_word_cnt", 64'(ifc.o_word_cnt), 64'(2*DEPTH));
    release dut.w_pop;
    drain(2*DEPTH + 64);
    check("drained_empty",  64'(ifc.o_empty),     64'd1);
    check("drained_pf",     64'(ifc.o_prog_full), 64'd0);
    check("ovf_sticky",     64'(ifc.o_overflow),  64'd1);

    sent = 0; cyc = 0;
    while (sent < 3*DEPTH && cyc < 20*DEPTH) begin
      if (ifc.o_full) step(1'b0, '0);
      else begin
        step(1'b1, {32'(2*sent), 32'(2*sent+1)});
        sent++;
      end
      cyc++;
    end
    check("wrap_sent", 64'(sent), 64'(3*DEPTH));
    drain(4*DEPTH);

    for (int i = 0; i < 4; i++) step(1'b1, {32'h7000_0000 + 32'(2*i), 32'h7000_0000 + 32'(2*i+1)});
    check("pre_rst_csib", 64'(ifc.o_icap_csib), 64'd0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_csib",      64'(ifc.o_icap_csib),  64'd1);
    check("mid_rst_rdwrb",     64'(ifc.o_icap_rdwrb), 64'd1);
    check("mid_rst_data",      64'(ifc.o_icap_data),  64'd0);
    check("mid_rst_empty",     64'(ifc.o_empty),      64'd1);
    check("mid_rst_full",      64'(ifc.o_full),       64'd0);
    check("mid_rst_prog_full", 64'(ifc.o_prog_full),  64'd0);
    check("mid_rst_overflow",  64'(ifc.o_overflow),   64'd0);
    check("mid_rst_word_cnt",  64'(ifc.o_word_cnt),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, '0);
    step(1'b1, vecs[0].din);
    step(1'b0, '0);
    check("post_rst_csib_n2", 64'(ifc.o_icap_csib), 64'd0);
    check("post_rst_data_n2", 64'(ifc.o_icap_data), 64'(vecs[0].exp0));
    drain(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
